// File: rtl/txn_pkg.sv
// txn_pkg: state encoding, process step codes and fail codes shared by the controller and datapath
package txn_pkg;
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_MEM   = 4'd1,
    S_GET_PLAYER = 4'd2,
    S_GET_AMOUNT = 4'd3,
    S_CHK_AMOUNT = 4'd4,
    S_GET_KEY    = 4'd5,
    S_CHK_KEY    = 4'd6,
    S_COMMIT     = 4'd7,
    S_COMMIT_WR  = 4'd8,
    S_PASS       = 4'd9,
    S_FAIL       = 4'd10
  } state_t;
  localparam logic [2:0] PROC_IDLE   = 3'b000;
  localparam logic [2:0] PROC_AMT    = 3'b001;
  localparam logic [2:0] PROC_KEY    = 3'b010;
  localparam logic [2:0] PROC_COMMIT = 3'b100;
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_AMT      = 2'b01;
  localparam logic [1:0] FC_KEY      = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;
endpackage

// File: rtl/transaction_control_if.sv
// transaction_control_if: controller-to-datapath strobes, step code and verify result
interface transaction_control_if;
  import txn_pkg::*;
  logic       load_register;
  logic       load_player;
  logic       load_amount;
  logic       load_key;
  logic       ledger_we;
  logic [2:0] process;
  logic       done_step;
  modport master (output load_register, load_player, load_amount, load_key, ledger_we, process, input done_step);
  modport slave  (input load_register, load_player, load_amount, load_key, ledger_we, process, output done_step);
endinterface

// File: rtl/press_detect.sv
// press_detect: one-cycle press on the rising edge of a synchronised button level
module press_detect (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic btn,
  output logic press
);
  logic btn_q;
  always_ff @(posedge clock) btn_q <= (!resetn || clear) ? 1'b0 : btn;
  assign press = btn & ~btn_q;
endmodule

// File: rtl/transaction_control.sv
// transaction_control: steps one coin transfer through the datapath; TXN_TIMEOUT_EN adds the CHK_KEY timeout exit
module transaction_control
  import txn_pkg::*;
#(
  parameter int KEY_TIMEOUT = 1023,
  parameter int AMT_SETTLE  = 3
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 go,
  input  logic                 abort,
  transaction_control_if.master bus,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [3:0]           state_dbg
);
  localparam logic [9:0] AMT_LAST = 10'(AMT_SETTLE - 1);
  state_t     state, state_n;
  logic [1:0] fc_n;
  logic [9:0] cnt, cnt_n;
  logic       raw_press, press, counting, strobe, strobe_q;
  press_detect u_press (.clock(clock), .resetn(resetn), .clear(abort), .btn(go), .press(raw_press));
  // a press right after a strobe is dropped so strobes never sit in adjacent cycles
  assign press = raw_press & ~strobe_q;
`ifdef TXN_TIMEOUT_EN
  localparam logic [9:0] KEY_LAST = 10'(KEY_TIMEOUT - 1);
  assign counting = state == S_CHK_AMOUNT || state == S_CHK_KEY;
`else
  logic unused_key_timeout;
  assign unused_key_timeout = ^KEY_TIMEOUT;
  assign counting = state == S_CHK_AMOUNT;
`endif
  always_comb begin
    state_n = state;
    fc_n = fail_code;
    case (state)
      S_IDLE:       if (press) state_n = S_LOAD_MEM;
      S_LOAD_MEM:   state_n = S_GET_PLAYER;
      S_GET_PLAYER: if (press) state_n = S_GET_AMOUNT;
      S_GET_AMOUNT: if (press) state_n = S_CHK_AMOUNT;
      S_CHK_AMOUNT: if (cnt == AMT_LAST) begin
        state_n = bus.done_step ? S_GET_KEY : S_FAIL;
        fc_n = FC_AMT;
      end
      S_GET_KEY:    if (press) state_n = S_CHK_KEY;
`ifdef TXN_TIMEOUT_EN
      S_CHK_KEY:    if (bus.done_step) state_n = S_COMMIT;
                    else if (cnt == KEY_LAST) begin
                      state_n = S_FAIL;
                      fc_n = FC_TIMEOUT;
                    end
`else
      S_CHK_KEY:    if (bus.done_step) state_n = S_COMMIT;
`endif
      S_COMMIT:     state_n = S_COMMIT_WR;
      S_COMMIT_WR:  state_n = S_PASS;
      S_PASS,
      S_FAIL:       if (press) state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
    if (state_n != S_FAIL) fc_n = FC_NONE;
    cnt_n = (counting && state_n == state) ? (&cnt ? cnt : cnt + 10'd1) : 10'd0;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      fail_code <= FC_NONE;
      cnt       <= 10'd0;
      strobe_q  <= 1'b0;
    end else begin
      state     <= state_n;
      fail_code <= fc_n;
      cnt       <= cnt_n;
      strobe_q  <= strobe;
    end
  end
  assign bus.load_register = state == S_LOAD_MEM && !abort;
  assign bus.load_player   = state == S_GET_PLAYER && press && !abort;
  assign bus.load_amount   = state == S_GET_AMOUNT && press && !abort;
  assign bus.load_key      = state == S_GET_KEY && press && !abort;
  assign bus.ledger_we     = state == S_COMMIT_WR && !abort;
  assign strobe = bus.load_register | bus.load_player | bus.load_amount | bus.load_key | bus.ledger_we;
  assign bus.process = state == S_CHK_AMOUNT ? PROC_AMT :
                       state == S_CHK_KEY    ? PROC_KEY :
                       state == S_COMMIT     ? PROC_COMMIT : PROC_IDLE;
  assign busy      = !(state == S_IDLE || state == S_PASS || state == S_FAIL);
  assign pass      = state == S_PASS;
  assign fail      = state == S_FAIL;
  assign state_dbg = state;
endmodule

// File: tb/tb_transaction_control.sv
// tb_transaction_control: directed scenarios with a strobe scoreboard checked by a negedge monitor
module tb_transaction_control;
  localparam logic [4:0] ST_REG = 5'b00001, ST_PLY = 5'b00010, ST_AMT = 5'b00100, ST_KEY = 5'b01000, ST_WE = 5'b10000;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0;
  logic abort = 1'b0;
  logic busy, pass, fail;
  logic [1:0] fail_code;
  logic [3:0] state_dbg;
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [4:0] mon_s;
  logic [8:0] mon_e;
  transaction_control_if bus();
  transaction_control #(.KEY_TIMEOUT(8), .AMT_SETTLE(3)) dut (
    .clock(clock), .resetn(resetn), .go(go), .abort(abort), .bus(bus),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code), .state_dbg(state_dbg)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    mon_s = {bus.ledger_we, bus.load_key, bus.load_amount, bus.load_player, bus.load_register};
    if (mon_s != 5'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got strobes=%b state=%0d, required none", mon_s, state_dbg);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mon_s, state_dbg} !== mon_e) begin
          failures++;
          $display("FAIL strobe: got strobes=%b state=%0d, required strobes=%b state=%0d", mon_s, state_dbg, mon_e[8:4], mon_e[3:0]);
        end
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic pulse_go();
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask
  task automatic expect_strobe(input logic [4:0] s, input logic [3:0] st);
    exp_q.push_back({s, st});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask
  task automatic to_chk_amount();
    expect_strobe(ST_REG, 4'd1);
    pulse_go();
    tick();
    expect_strobe(ST_PLY, 4'd2);
    pulse_go();
    expect_strobe(ST_AMT, 4'd3);
    pulse_go();
  endtask
  task automatic to_chk_key();
    to_chk_amount();
    tick();
    bus.done_step = 1'b1;
    tick(2);
    bus.done_step = 1'b0;
    expect_strobe(ST_KEY, 4'd5);
    pulse_go();
  endtask
  initial begin
    bus.done_step = 1'b0;
    tick(2);
    chk("reset_outputs", {bus.load_register, bus.load_player, bus.load_amount, bus.load_key, bus.ledger_we,
                          bus.process, busy, pass, fail, fail_code, state_dbg}, 0);
    resetn = 1'b1;
    to_chk_amount();
    chk("amt_state", state_dbg, 4);
    chk("amt_process", bus.process, 3'b001);
    tick();
    bus.done_step = 1'b1;
    tick();
    chk("amt_settle_last", state_dbg, 4);
    tick();
    chk("amt_ok_get_key", state_dbg, 5);
    bus.done_step = 1'b0;
    expect_strobe(ST_KEY, 4'd5);
    pulse_go();
    chk("key_process", bus.process, 3'b010);
    tick(4);
    bus.done_step = 1'b1;
    tick();
    bus.done_step = 1'b0;
    chk("commit_state", state_dbg, 7);
    chk("commit_process", bus.process, 3'b100);
    expect_strobe(ST_WE, 4'd8);
    tick();
    chk("commit_wr_state", state_dbg, 8);
    tick();
    chk("pass_status", {pass, fail, fail_code, busy, state_dbg}, {1'b1, 1'b0, 2'b00, 1'b0, 4'd9});
    pulse_go();
    chk("pass_to_idle", {pass, state_dbg}, {1'b0, 4'd0});
    to_chk_amount();
    tick(2);
    chk("reject_settle_last", state_dbg, 4);
    tick();
    chk("reject_status", {pass, fail, fail_code, busy, state_dbg}, {1'b0, 1'b1, 2'b01, 1'b0, 4'd10});
    pulse_go();
    chk("fail_to_idle", {fail, fail_code, state_dbg}, {1'b0, 2'b00, 4'd0});
    expect_strobe(ST_REG, 4'd1);
    pulse_go();
    tick(2);
    expect_strobe(ST_PLY, 4'd2);
    go = 1'b1;
    tick(50);
    go = 1'b0;
    chk("held_go_state", state_dbg, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_get_amount", {busy, state_dbg}, {1'b0, 4'd0});
    to_chk_key();
    tick();
    bus.done_step = 1'b1;
    tick();
    bus.done_step = 1'b0;
    chk("short_commit", state_dbg, 7);
    tick();
    chk("short_commit_wr", state_dbg, 8);
    abort = 1'b1;
    #1;
    chk("abort_we_suppressed", bus.ledger_we, 0);
    tick();
    abort = 1'b0;
    chk("abort_commit_wr", {busy, pass, fail, fail_code, state_dbg}, 0);
    to_chk_key();
`ifdef TXN_TIMEOUT_EN
    tick(7);
    chk("timeout_8th_cycle", state_dbg, 6);
    tick();
    chk("timeout_status", {fail, fail_code, state_dbg}, {1'b1, 2'b11, 4'd10});
    pulse_go();
    chk("timeout_to_idle", state_dbg, 0);
`else
    tick(2000);
    chk("no_timeout_state", {busy, bus.process, state_dbg}, {1'b1, 3'b010, 4'd6});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("no_timeout_abort", state_dbg, 0);
`endif
    to_chk_key();
    tick(2);
    resetn = 1'b0;
    tick();
    chk("midrun_reset", {bus.load_register, bus.load_player, bus.load_amount, bus.load_key, bus.ledger_we,
                         bus.process, busy, pass, fail, fail_code, state_dbg}, 0);
    resetn = 1'b1;
    expect_strobe(ST_REG, 4'd1);
    pulse_go();
    chk("reset_first_press", state_dbg, 1);
    tick(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/transaction_control.md
# transaction_control

Sequencing controller for the coin-transfer datapath. It steps a single transfer through a fixed order: latch the ledger, pick the player, latch the amount, verify the amount, latch the key, verify the key, then write the updated ledger back. It drives the datapath's load strobes and `process` code, and qualifies the datapath's `done_step` result. It also owns the ledger write-enable and exposes pass/fail status to the board-level display logic.

## Interface
- `KEY_TIMEOUT`, default 1023: maximum cycles to wait in key verification before failing.
- `AMT_SETTLE`, default 3: cycles to hold `process`=001 before sampling the amount result.
- `clock`  in  1: the single system clock; all state changes on the rising edge.
- `resetn`  in  1: reset, synchronous and active-low.
- `go`  in  1: user advance button, level, synchronised upstream; the block detects its rising edge internally.
- `abort`  in  1: level; forces a return to IDLE from any state.
- `done_step`  in  1: registered verify result from the datapath.
- `load_register`  out  1: one-cycle strobe that latches the ledger into the datapath.
- `load_player`, `load_amount`, `load_key`  out  1 each: one-cycle strobes to the datapath.
- `process`  out  3: datapath step code (000 idle, 001 verify amount, 010 verify key, 100 commit).
- `ledger_we`  out  1: one-cycle write strobe for the ledger memory (captures `result_out`).
- `busy`  out  1: high in every state except IDLE, PASS and FAIL.
- `pass`, `fail`  out  1 each: level status, mutually exclusive.
- `fail_code`  out  2: 00 none, 01 amount, 10 key, 11 timeout.
- `state_dbg`  out  4: current state encoding, for HEX display.

## Operation
- The edge detector compares `go` with a one-cycle delayed copy; a "press" is the cycle where `go`=1 and the delayed copy=0. A held `go` produces exactly one press.
- The state machine has these states and transitions:
  - IDLE moves to LOAD_MEM on a press.
  - LOAD_MEM pulses `load_register` for one cycle, then moves to GET_PLAYER.
  - GET_PLAYER waits for a press, pulses `load_player` on that cycle, then moves to GET_AMOUNT.
  - GET_AMOUNT waits for a press, pulses `load_amount`, then moves to CHK_AMOUNT.
  - CHK_AMOUNT drives `process`=001 for `AMT_SETTLE` cycles, then samples `done_step`. If it is 1 the machine moves to GET_KEY; if 0 it moves to FAIL with code 01.
  - GET_KEY waits for a press, pulses `load_key`, then moves to CHK_KEY.
  - CHK_KEY drives `process`=010 and counts cycles. On `done_step`=1 it moves to COMMIT.
  - COMMIT drives `process`=100 for one cycle. On the following cycle (COMMIT_WR) it pulses `ledger_we`, then moves to PASS.
  - PASS and FAIL hold their status outputs; a press returns the machine to IDLE.
- Strobes are issued only in the states listed above and are never high in two consecutive cycles.
- `process` is 000 in every state not listed above.
- `abort` has priority over every transition. It forces IDLE on the next edge, with no `ledger_we` and with status cleared. If `abort` arrives in COMMIT_WR, the write is suppressed.
- A press that arrives while the machine is in a CHK_* state is ignored and is not queued.

## Timing
- Reset, and `abort`, are synchronous: the edge they act on puts the machine in IDLE, all outputs at 0, `fail_code`=00, the counters at 0 and the delayed-`go` copy at 0.
- Press to strobe latency: the strobe is combinational from state plus press, so it is asserted in the press cycle and the datapath latches it on the next edge.
- The amount check holds `process`=001 for exactly `AMT_SETTLE` cycles and samples on the last one.
- The key counter is 10 bits wide and saturates. On the `KEY_TIMEOUT`-th cycle in CHK_KEY without `done_step`, the machine moves to FAIL with code 11. If `done_step` and timeout occur in the same cycle, `done_step` wins.
- The shortest path from the key strobe to `ledger_we` is 4 cycles, when `done_step` rises one cycle after CHK_KEY is entered.
- `pass` and `fail` go high in the first cycle of PASS or FAIL.

## Configuration
- `TXN_TIMEOUT_EN` defined: the CHK_KEY counter and the code-11 exit are compiled in.
- `TXN_TIMEOUT_EN` undefined: the counter is removed. CHK_KEY waits indefinitely for `done_step` and leaves only on `done_step` or `abort`. Code 11 is never produced, and `KEY_TIMEOUT` is ignored.

## Structure
- A shared package `txn_pkg` holds:
  - the state encoding (4-bit constants);
  - the `process` codes PROC_IDLE, PROC_AMT, PROC_KEY, PROC_COMMIT;
  - the `fail_code` constants.
- The datapath imports the same `process` constants.
- One sub-module, `press_detect`, is the rising-edge detector on `go`. It is reused for other board buttons.

## Test plan
- Happy path: the bench gives five presses, then `done_step`=1 two cycles into CHK_AMOUNT and again on the 5th CHK_KEY cycle. Required: one pulse each of `load_register`, `load_player`, `load_amount`, `load_key` and `ledger_we`; `pass`=1, `fail_code`=00.
- Amount reject: `done_step`=0 at the end of the 3-cycle CHK_AMOUNT. Required: `fail`=1, `fail_code`=01, and `load_key` and `ledger_we` never pulse.
- Key timeout with `TXN_TIMEOUT_EN` defined and `KEY_TIMEOUT`=8: `done_step` stays 0. Required: FAIL on the 8th CHK_KEY cycle with `fail_code`=11. With the macro undefined, the machine is still in CHK_KEY after 2000 cycles.
- Held `go`: `go` is high for 50 cycles in GET_PLAYER. Required: exactly one `load_player` pulse and no advance past GET_AMOUNT.
- Abort in COMMIT_WR: `abort`=1 is applied in that cycle. Required: `ledger_we` stays 0, and the machine is in IDLE with `busy`=0 on the next edge.
- Reset mid-run: `resetn`=0 for 1 cycle during CHK_KEY. Required: the machine is in IDLE with all outputs 0 on the next edge, and the first press afterwards goes to LOAD_MEM.
